// File: rtl/ip_codma_xfer_sequencer_if.sv
// ip_codma_xfer_sequencer_if: request/done handshake between the sequencer and the read/write machines.
interface ip_codma_xfer_sequencer_if #(parameter int ADDR_W = 32);
  logic              rd_req, rd_done, rd_error;
  logic              wr_req, wr_done, wr_error;
  logic              stop;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [3:0]        rd_size, wr_size;
  modport master(
    output rd_req, rd_addr, rd_size, wr_req, wr_addr, wr_size, stop,
    input  rd_done, rd_error, wr_done, wr_error
  );
  modport slave(
    input  rd_req, rd_addr, rd_size, wr_req, wr_addr, wr_size, stop,
    output rd_done, rd_error, wr_done, wr_error
  );
endinterface

// File: rtl/ip_codma_xfer_sequencer.sv
// ip_codma_xfer_sequencer: splits a copy job into 32/16/8 B read-then-write bursts with abort, error and timeout handling.
module ip_codma_xfer_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   src_addr_i,
  input  logic [ADDR_W-1:0]   dst_addr_i,
  input  logic [LEN_W-1:0]    len_i,
  input  logic                stop_i,
  input  logic                err_clr_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic [2:0]          err_code_o,
  output logic [LEN_W-1:0]    bytes_moved_o,
  ip_codma_xfer_sequencer_if.master xfer
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;
  logic [2:0]        state, state_nxt, code_nxt, fail;
  logic [ADDR_W-1:0] src, dst;
  logic [LEN_W-1:0]  rem, rem_nxt, blen;
  logic [3:0]        size;
  logic [CW-1:0]     cnt;
  logic              abort, in_wait, timeout, misalign, step;
  logic              rd_req_q, wr_req_q, stop_q;
  function automatic logic [3:0] code_of(input logic [LEN_W-1:0] n);
    return n >= LEN_W'(32) ? 4'd9 : n >= LEN_W'(16) ? 4'd8 : 4'd3;
  endfunction
  assign blen     = size == 4'd9 ? LEN_W'(32) : size == 4'd8 ? LEN_W'(16) : LEN_W'(8);
  assign rem_nxt  = rem - blen;
  assign abort    = stop_i && state != S_IDLE && state != S_ERROR;
  assign in_wait  = state == S_RD_WAIT || state == S_WR_WAIT;
  assign timeout  = in_wait && cnt == CW'(TIMEOUT - 1);
  assign misalign = |{src_addr_i[2:0], dst_addr_i[2:0], len_i[2:0]};
  // Machine errors outrank timeout; a misaligned job is reported as a config error at start.
  assign fail = state == S_RD_WAIT && xfer.rd_error ? 3'd2 :
                state == S_WR_WAIT && xfer.wr_error ? 3'd3 :
                timeout                             ? 3'd4 :
                state == S_IDLE && start_i && misalign ? 3'd1 : 3'd0;
  assign step = state == S_WR_WAIT && (state_nxt == S_RD_REQ || state_nxt == S_DONE);
  always_comb begin
    state_nxt = state;
    code_nxt  = err_code_o;
    if (abort) state_nxt = S_IDLE;
    else if (fail != 3'd0) begin
      state_nxt = S_ERROR;
      code_nxt  = fail;
    end else
      case (state)
        S_IDLE:    if (start_i) state_nxt = len_i == '0 ? S_DONE : S_RD_REQ;
        S_RD_REQ:  state_nxt = S_RD_WAIT;
        S_RD_WAIT: if (xfer.rd_done) state_nxt = S_WR_REQ;
        S_WR_REQ:  state_nxt = S_WR_WAIT;
        S_WR_WAIT: if (xfer.wr_done) state_nxt = rem_nxt == '0 ? S_DONE : S_RD_REQ;
        S_DONE:    state_nxt = S_IDLE;
        S_ERROR:   if (err_clr_i) begin
          state_nxt = S_IDLE;
          code_nxt  = 3'd0;
        end
        default:   state_nxt = S_IDLE;
      endcase
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state         <= S_IDLE;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      error_o       <= 1'b0;
      err_code_o    <= 3'd0;
      bytes_moved_o <= '0;
      rd_req_q      <= 1'b0;
      wr_req_q      <= 1'b0;
      stop_q        <= 1'b0;
      src           <= '0;
      dst           <= '0;
      rem           <= '0;
      size          <= 4'd0;
      cnt           <= '0;
    end else begin
      state      <= state_nxt;
      busy_o     <= state_nxt != S_IDLE;
      done_o     <= state_nxt == S_DONE;
      error_o    <= state_nxt == S_ERROR;
      err_code_o <= code_nxt;
      rd_req_q   <= state_nxt == S_RD_REQ;
      wr_req_q   <= state_nxt == S_WR_REQ;
      stop_q     <= abort || (state_nxt == S_ERROR && state != S_ERROR);
      cnt        <= in_wait && state_nxt == state ? cnt + CW'(1) : '0;
      if (state == S_IDLE && start_i) begin
        src           <= src_addr_i;
        dst           <= dst_addr_i;
        rem           <= len_i;
        bytes_moved_o <= '0;
      end
      if (step) begin
        src           <= src + ADDR_W'(blen);
        dst           <= dst + ADDR_W'(blen);
        rem           <= rem_nxt;
        bytes_moved_o <= bytes_moved_o + blen;
      end
      // Size is fixed for the whole burst, chosen from what is left when the read is issued.
      if (state_nxt == S_RD_REQ) size <= code_of(state == S_IDLE ? len_i : rem_nxt);
    end
  end
  assign xfer.rd_req  = rd_req_q;
  assign xfer.wr_req  = wr_req_q;
  assign xfer.stop    = stop_q;
  assign xfer.rd_addr = src;
  assign xfer.wr_addr = dst;
  assign xfer.rd_size = size;
  assign xfer.wr_size = size;
endmodule

// File: doc/ip_codma_xfer_sequencer.md
# ip_codma_xfer_sequencer

Single-channel transfer sequencer for the codma datapath. Takes a software-programmed copy job (source address, destination address, byte length) and splits it into 64-bit-aligned bursts. Each burst is issued as one read request to the read machine, then one write request to the write machine. Sits between the top-level register/descriptor logic and the read/write machine pair. It owns burst sizing, address stepping, job completion, abort and error capture.

## Interface
- ADDR_W, 32, address width of src/dst
- LEN_W, 16, width of job length in bytes
- TIMEOUT, 1024, max cycles spent in any wait state before timeout error
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  job start; sampled only in IDLE
- src_addr_i  in  ADDR_W  job source byte address
- dst_addr_i  in  ADDR_W  job destination byte address
- len_i  in  LEN_W  job length in bytes
- stop_i  in  1  abort current job
- err_clr_i  in  1  leave ERROR state
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse on successful job completion
- error_o  out  1  high while in ERROR
- err_code_o  out  3  0 none, 1 config, 2 read, 3 write, 4 timeout
- bytes_moved_o  out  LEN_W  bytes fully written in current/last job
- rd_req_o  out  1  one-cycle read request to the read machine
- rd_addr_o  out  ADDR_W  current read address
- rd_size_o  out  4  burst size code: 9 = 32 B, 8 = 16 B, 3 = 8 B
- rd_done_i  in  1  read machine burst complete (one-cycle pulse)
- rd_error_i  in  1  read machine / bus error
- wr_req_o, wr_addr_o, wr_size_o, wr_done_i, wr_error_i: write-side equivalents, same widths and semantics
- stop_o  out  1  one-cycle pulse to both machines on abort or error

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE, ERROR.
- Job start (IDLE with start_i):
  - Capture src, dst and remaining = len_i, and clear bytes_moved_o.
  - If src[2:0] != 0, dst[2:0] != 0 or len_i[2:0] != 0, go to ERROR with code 1.
  - Else if len_i == 0, go to DONE.
  - Else go to RD_REQ.
- Burst size, chosen from remaining on entry to RD_REQ and held for the whole burst:
  - remaining >= 32: code 9, 32 B.
  - remaining >= 16: code 8, 16 B.
  - otherwise: code 3, 8 B.
- RD_REQ: rd_req_o = 1 for that cycle, then go to RD_WAIT.
- RD_WAIT: on rd_done_i, go to WR_REQ.
- WR_REQ: wr_req_o = 1 for that cycle, wr_size_o = same code as the read, then go to WR_WAIT.
- WR_WAIT: on wr_done_i, step the counters, then branch:
  - src and dst each increase by the burst bytes.
  - remaining decreases by the burst bytes; bytes_moved_o increases by the burst bytes.
  - If the new remaining is 0, go to DONE; else go to RD_REQ.
- DONE: done_o = 1 for one cycle, then go to IDLE.
- rd_error_i in RD_WAIT goes to ERROR with code 2. wr_error_i in WR_WAIT goes to ERROR with code 3. Errors from either machine are ignored in other states.
- Wait-cycle counter:
  - Clears on entry to RD_WAIT or WR_WAIT.
  - Increments while in either wait state.
  - Reaching TIMEOUT-1 without done goes to ERROR with code 4.
- ERROR:
  - stop_o pulses on the entry cycle.
  - error_o and err_code_o hold.
  - err_clr_i goes to IDLE and clears err_code_o.
  - start_i is ignored while in ERROR.
- stop_i in any busy state except ERROR: pulse stop_o, go to IDLE, no done_o. bytes_moved_o keeps its partial value.
- Priority, highest first: stop_i, error, timeout, done. stop_i with rd_done_i or wr_done_i in the same cycle aborts and does not step the counters.
- start_i while busy is ignored.
- Address arithmetic wraps modulo 2^ADDR_W with no error.

## Timing
- Reset values:
  - All outputs are 0: busy, done, error, err_code, bytes_moved, rd/wr req, addr, size, stop.
  - State is IDLE.
- All outputs are registered; state changes on the clock edge after the input condition.
- Latency milestones:
  - start_i sampled at edge N; busy_o and RD_REQ at N+1, with rd_req_o high during cycle N+1.
  - rd_done_i at edge M; wr_req_o high during cycle M+1.
  - Final wr_done_i at edge K; done_o high during cycle K+1; busy_o low from K+2.
- rd_addr_o, wr_addr_o and both size codes are valid and stable from the req cycle until the matching done.
- The wait-state done inputs are single-cycle pulses. A done input arriving outside its wait state is ignored.
- Asynchronous reset mid-job returns immediately to IDLE with all outputs 0. The sequencer does not pulse stop_o; the machines are reset by the same signal.

## Test plan
- len=56, src=0x1000, dst=0x2000:
  - Bursts are 32/16/8 B, with rd_addr 0x1000 / 0x1020 / 0x1030 and wr_addr 0x2000 / 0x2020 / 0x2030.
  - Size codes are 9/8/3.
  - done_o is one pulse; bytes_moved_o = 56.
- len=0 -> done_o one cycle after the start cycle, no rd_req_o. src=0x1004 -> ERROR code 1, stop_o pulse, no req.
- rd_error_i on the second burst of len=64 -> ERROR code 2, bytes_moved_o = 32. err_clr_i -> IDLE, err_code_o = 0.
- Read machine never returns done -> ERROR code 4 exactly TIMEOUT cycles after entering RD_WAIT, stop_o pulsed.
- stop_i in the same cycle as wr_done_i on the first burst -> IDLE, stop_o pulse, bytes_moved_o = 0, no done_o.
- start_i pulsed in WR_WAIT -> ignored. Reset asserted in RD_WAIT -> all outputs 0, IDLE.
